elevator_scheduler: RTL and testbench

ELEVATOR_SCHEDULER -- requirements
Module: elevator_scheduler

---
 rtl/elevator_pkg.sv | 18 +
 rtl/elevator_timer.sv | 34 +++
 rtl/elevator_scheduler.sv | 158 +++++++++++++++
 tb/tb_elevator_scheduler.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator scheduler slice.
package elevator_pkg;

  localparam int unsigned FLOOR_W               = 3;
  localparam int unsigned TIMER_W               = 16;
  localparam int unsigned DEFAULT_TRAVEL_CYCLES = 16;
  localparam int unsigned DEFAULT_DOOR_CYCLES   = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MOVE   = 3'd1,
    ST_ARRIVE = 3'd2,
    ST_DOOR   = 3'd3,
    ST_CLEAR  = 3'd4,
    ST_SETTLE = 3'd5
  } state_t;

endpackage

// File: rtl/elevator_timer.sv
// Load/count-down timer shared by the travel and door phases.
// done pulses for one cycle when a loaded count has run down to zero.
module elevator_timer
  import elevator_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] value,
  output logic               done
);

  logic [TIMER_W-1:0] count;
  logic               running;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count   <= '0;
      running <= 1'b0;
    end else if (load) begin
      count   <= value;
      running <= 1'b1;
    end else if (running) begin
      if (count == '0) begin
        running <= 1'b0;
      end else begin
        count <= count - 1'b1;
      end
    end
  end

  assign done = running && (count == '0);

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN-order elevator car controller driving an external request queue.
// Serves requests ahead of the car before reversing; clears each served floor.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int unsigned FLOOR_COUNT   = 7,
  parameter int unsigned TRAVEL_CYCLES = DEFAULT_TRAVEL_CYCLES,
  parameter int unsigned DOOR_CYCLES   = DEFAULT_DOOR_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [FLOOR_COUNT-1:0] queue_status,
  output logic                   q_r_nwr,
  output logic                   q_deassert_floor,
  output logic [FLOOR_W-1:0]     q_requested_floor,
  output logic [FLOOR_W-1:0]     current_floor,
  output logic                   direction,
  output logic                   moving,
  output logic                   door_open
);

  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(FLOOR_COUNT - 1);
  // The timer load is registered, so the first cycle of a phase is the load
  // cycle; loading N-2 makes the phase last exactly N cycles (N >= 2).
  localparam logic [TIMER_W-1:0] MOVE_LOAD = TIMER_W'(TRAVEL_CYCLES - 2);
  localparam logic [TIMER_W-1:0] DOOR_LOAD = TIMER_W'(DOOR_CYCLES - 2);

  state_t             state;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_value;
  logic               timer_done;
  logic               req_here;
  logic               req_above;
  logic               req_below;
  logic               req_ahead;
  logic [31:0]        cur_idx;

  assign cur_idx   = 32'(current_floor);
  assign req_ahead = direction ? req_above : req_below;

  always_comb begin
    req_here  = 1'b0;
    req_above = 1'b0;
    req_below = 1'b0;
    for (int unsigned i = 0; i < FLOOR_COUNT; i++) begin
      if (queue_status[i]) begin
        if (i == cur_idx) begin
          req_here = 1'b1;
        end else if (i > cur_idx) begin
          req_above = 1'b1;
        end else begin
          req_below = 1'b1;
        end
      end
    end
  end

  elevator_timer u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (timer_load),
    .value   (timer_value),
    .done    (timer_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= ST_IDLE;
      current_floor     <= '0;
      direction         <= 1'b1;
      moving            <= 1'b0;
      door_open         <= 1'b0;
      q_r_nwr           <= 1'b1;
      q_deassert_floor  <= 1'b0;
      q_requested_floor <= '0;
      timer_load        <= 1'b0;
      timer_value       <= '0;
    end else begin
      timer_load <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_here) begin
            state       <= ST_DOOR;
            door_open   <= 1'b1;
            timer_load  <= 1'b1;
            timer_value <= DOOR_LOAD;
          end else if (req_above && (direction || !req_below)) begin
            state       <= ST_MOVE;
            direction   <= 1'b1;
            moving      <= 1'b1;
            timer_load  <= 1'b1;
            timer_value <= MOVE_LOAD;
          end else if (req_below) begin
            state       <= ST_MOVE;
            direction   <= 1'b0;
            moving      <= 1'b1;
            timer_load  <= 1'b1;
            timer_value <= MOVE_LOAD;
          end
        end

        ST_MOVE: begin
          if (timer_done) begin
            state  <= ST_ARRIVE;
            moving <= 1'b0;
            if (direction && (current_floor != TOP_FLOOR)) begin
              current_floor <= current_floor + 1'b1;
            end else if (!direction && (current_floor != '0)) begin
              current_floor <= current_floor - 1'b1;
            end
          end
        end

        ST_ARRIVE: begin
          // Only continues in the current direction; reversal is left to IDLE.
          if (req_here) begin
            state       <= ST_DOOR;
            door_open   <= 1'b1;
            timer_load  <= 1'b1;
            timer_value <= DOOR_LOAD;
          end else if (req_ahead) begin
            state       <= ST_MOVE;
            moving      <= 1'b1;
            timer_load  <= 1'b1;
            timer_value <= MOVE_LOAD;
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_DOOR: begin
          if (timer_done) begin
            state             <= ST_CLEAR;
            door_open         <= 1'b0;
            q_r_nwr           <= 1'b0;
            q_deassert_floor  <= 1'b1;
            q_requested_floor <= current_floor;
          end
        end

        ST_CLEAR: begin
          state            <= ST_SETTLE;
          q_r_nwr          <= 1'b1;
          q_deassert_floor <= 1'b0;
        end

        ST_SETTLE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_scheduler.sv
// Scenario bench for elevator_scheduler with a behavioural request queue and
// a scoreboard of expected floor-clear writes.
module tb_elevator_scheduler;

  localparam int unsigned FC   = 7;
  localparam int unsigned TRAV = 16;
  localparam int unsigned DOOR = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [FC-1:0] q_bits;
  logic [FC-1:0] req_set = '0;
  logic [FC-1:0] queue_status;
  logic          q_r_nwr;
  logic          q_deassert_floor;
  logic [2:0]    q_requested_floor;
  logic [2:0]    current_floor;
  logic          direction;
  logic          moving;
  logic          door_open;

  int total = 0;
  int bad = 0;
  int writes_seen = 0;
  int move_phases = 0;
  int mv_run = 0;
  int dr_run = 0;
  logic [2:0] exp_q[$];
  logic [2:0] exp_floor;

  elevator_scheduler #(
    .FLOOR_COUNT  (FC),
    .TRAVEL_CYCLES(TRAV),
    .DOOR_CYCLES  (DOOR)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .queue_status     (queue_status),
    .q_r_nwr          (q_r_nwr),
    .q_deassert_floor (q_deassert_floor),
    .q_requested_floor(q_requested_floor),
    .current_floor    (current_floor),
    .direction        (direction),
    .moving           (moving),
    .door_open        (door_open)
  );

  always #5 clk = ~clk;

  // Request queue: new requests latch in, a clear write removes one floor.
  assign queue_status = q_bits | req_set;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_bits <= '0;
    end else begin
      q_bits <= (q_bits | req_set) &
                ((!q_r_nwr && q_deassert_floor) ? ~(FC'(1) << q_requested_floor) : '1);
    end
  end

  // Monitor: phase lengths, floor bound and scoreboard of clear writes.
  always @(negedge clk) begin
    if (!reset_n) begin
      mv_run = 0;
      dr_run = 0;
    end else begin
      if (moving) begin
        if (mv_run == 0) move_phases++;
        mv_run++;
      end else if (mv_run != 0) begin
        total++;
        if (mv_run !== TRAV) begin
          bad++;
          $display("FAIL move_len got=%0d want=%0d", mv_run, TRAV);
        end
        mv_run = 0;
      end
      if (door_open) begin
        dr_run++;
      end else if (dr_run != 0) begin
        total++;
        if (dr_run !== DOOR) begin
          bad++;
          $display("FAIL door_len got=%0d want=%0d", dr_run, DOOR);
        end
        dr_run = 0;
      end
      total++;
      if (current_floor > 3'(FC - 1)) begin
        bad++;
        $display("FAIL floor_bound got=%0d want<=%0d", current_floor, FC - 1);
      end
      if (!q_r_nwr) begin
        writes_seen++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write got_floor=%0d want=none", q_requested_floor);
        end else begin
          exp_floor = exp_q.pop_front();
          if (q_requested_floor !== exp_floor || q_deassert_floor !== 1'b1) begin
            bad++;
            $display("FAIL clear_write got floor=%0d deassert=%0b want floor=%0d deassert=1",
                     q_requested_floor, q_deassert_floor, exp_floor);
          end
        end
      end
    end
  end

  task automatic pulse_req(input logic [FC-1:0] mask);
    req_set = mask;
    @(negedge clk);
    req_set = '0;
  endtask

  task automatic wait_served(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL serve_timeout pending=%0d want=0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_moving_from(input logic [2:0] floor, input int budget);
    int n;
    n = 0;
    while (!(current_floor == floor && moving) && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!(current_floor == floor && moving)) begin
      bad++;
      $display("FAIL wait_floor got=%0d moving=%0b want=%0d moving=1", current_floor, moving, floor);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({current_floor, direction, moving, door_open, q_r_nwr, q_deassert_floor, q_requested_floor}
        !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0}) begin
      bad++;
      $display("FAIL reset_values got floor=%0d dir=%0b mov=%0b door=%0b rnw=%0b deas=%0b rq=%0d want 0 1 0 0 1 0 0",
               current_floor, direction, moving, door_open, q_r_nwr, q_deassert_floor, q_requested_floor);
    end
    #2 reset_n = 1'b1;
    repeat (10) @(negedge clk);
    total++;
    if ({current_floor, direction, moving, door_open, q_r_nwr, q_deassert_floor}
        !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL idle_hold got floor=%0d dir=%0b mov=%0b door=%0b rnw=%0b deas=%0b want 0 1 0 0 1 0",
               current_floor, direction, moving, door_open, q_r_nwr, q_deassert_floor);
    end
  endtask

  task automatic test_single_trip();
    int phases0;
    phases0 = move_phases;
    exp_q.push_back(3'd3);
    pulse_req(7'b0001000);
    total++;
    if (moving !== 1'b1) begin
      bad++;
      $display("FAIL decide_latency got moving=%0b want=1", moving);
    end
    wait_served(400);
    total++;
    if (current_floor !== 3'd3) begin
      bad++;
      $display("FAIL trip_floor got=%0d want=3", current_floor);
    end
    total++;
    if (move_phases - phases0 !== 3) begin
      bad++;
      $display("FAIL trip_phases got=%0d want=3", move_phases - phases0);
    end
  endtask

  task automatic test_scan_order();
    exp_q.push_back(3'd5);
    exp_q.push_back(3'd1);
    pulse_req(7'b0100010);
    total++;
    if (direction !== 1'b1 || moving !== 1'b1) begin
      bad++;
      $display("FAIL scan_start got dir=%0b mov=%0b want dir=1 mov=1", direction, moving);
    end
    wait_served(600);
    total++;
    if (current_floor !== 3'd1 || direction !== 1'b0) begin
      bad++;
      $display("FAIL scan_end got floor=%0d dir=%0b want floor=1 dir=0", current_floor, direction);
    end
  endtask

  task automatic test_request_here();
    int phases0;
    exp_q.push_back(3'd0);
    pulse_req(7'b0000001);
    wait_served(300);
    phases0 = move_phases;
    exp_q.push_back(3'd0);
    pulse_req(7'b0000001);
    total++;
    if (door_open !== 1'b1 || moving !== 1'b0) begin
      bad++;
      $display("FAIL here_door got door=%0b mov=%0b want door=1 mov=0", door_open, moving);
    end
    wait_served(200);
    total++;
    if (move_phases !== phases0 || current_floor !== 3'd0) begin
      bad++;
      $display("FAIL here_nomove got phases=%0d floor=%0d want phases=%0d floor=0",
               move_phases, current_floor, phases0);
    end
  endtask

  task automatic test_absorb_during_door();
    int w0;
    w0 = writes_seen;
    exp_q.push_back(3'd0);
    pulse_req(7'b0000001);
    repeat (10) @(negedge clk);
    pulse_req(7'b0000001);
    wait_served(200);
    repeat (40) @(negedge clk);
    total++;
    if (writes_seen - w0 !== 1 || queue_status !== '0) begin
      bad++;
      $display("FAIL absorb got writes=%0d status=%b want writes=1 status=0000000",
               writes_seen - w0, queue_status);
    end
  endtask

  task automatic test_top_floor();
    exp_q.push_back(3'd6);
    pulse_req(7'b1000000);
    wait_served(800);
    exp_q.push_back(3'd6);
    pulse_req(7'b1000000);
    total++;
    if (door_open !== 1'b1 || moving !== 1'b0) begin
      bad++;
      $display("FAIL top_door got door=%0b mov=%0b want door=1 mov=0", door_open, moving);
    end
    wait_served(200);
    total++;
    if (current_floor !== 3'd6) begin
      bad++;
      $display("FAIL top_floor got=%0d want=6", current_floor);
    end
    exp_q.push_back(3'd0);
    pulse_req(7'b0000001);
    total++;
    if (direction !== 1'b0 || moving !== 1'b1) begin
      bad++;
      $display("FAIL top_reverse got dir=%0b mov=%0b want dir=0 mov=1", direction, moving);
    end
    wait_served(800);
    total++;
    if (current_floor !== 3'd0) begin
      bad++;
      $display("FAIL descend_floor got=%0d want=0", current_floor);
    end
  endtask

  task automatic test_passed_floor();
    exp_q.push_back(3'd5);
    pulse_req(7'b0100000);
    wait_moving_from(3'd2, 300);
    exp_q.push_back(3'd1);
    pulse_req(7'b0000010);
    total++;
    if (direction !== 1'b1) begin
      bad++;
      $display("FAIL sweep_dir got=%0b want=1", direction);
    end
    wait_served(800);
    total++;
    if (current_floor !== 3'd1) begin
      bad++;
      $display("FAIL return_floor got=%0d want=1", current_floor);
    end
  endtask

  task automatic test_reset_mid_move();
    int w0;
    pulse_req(7'b0010000);
    wait_moving_from(3'd2, 300);
    repeat (5) @(negedge clk);
    w0 = writes_seen;
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (current_floor !== 3'd0 || moving !== 1'b0 || q_r_nwr !== 1'b1 || q_deassert_floor !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got floor=%0d mov=%0b rnw=%0b deas=%0b want 0 0 1 0",
               current_floor, moving, q_r_nwr, q_deassert_floor);
    end
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (60) @(negedge clk);
    total++;
    if (writes_seen !== w0 || current_floor !== 3'd0 || moving !== 1'b0) begin
      bad++;
      $display("FAIL reset_abandon got writes=%0d floor=%0d mov=%0b want writes=%0d floor=0 mov=0",
               writes_seen, current_floor, moving, w0);
    end
  endtask

  initial begin
    test_reset();
    test_single_trip();
    test_scan_order();
    test_request_here();
    test_absorb_during_door();
    test_top_floor();
    test_passed_floor();
    test_reset_mid_move();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout reached want=finish");
    $fatal(1, "timeout");
  end

endmodule
